// File: rtl/rrs_stream_if.sv
// Stream bundle for the rotate-right realigner: input beat side and output beat side.
interface rrs_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT_BITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_shift_enable;
    logic [SHIFT_BITS-1:0] in_shift_count;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_shift_enable, in_shift_count, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_shift_enable, in_shift_count, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rrs_stream.sv
// Streaming rotate-right realigner with output register, one-entry skid buffer,
// frame counting and sticky illegal-code flag.
module rrs_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_CLUSTERS = 8,
    parameter int SHIFT_BITS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    rrs_stream_if.slave bus,
    output logic        err_illegal,
    output logic [15:0] frame_count
);
    typedef enum logic [1:0] {ST_EMPTY, ST_OUT, ST_SKID} state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_out_data, r_skid_data, w_rot;
    logic                  r_out_last, r_skid_last, r_err;
    logic [15:0]           r_frames;
    logic [7:0]            w_code;
    logic                  w_illegal, w_accept, w_xfer;
    logic                  w_load_in, w_skid_to_out, w_fill_skid;

    assign w_code = 8'(bus.in_shift_count);

    // Illegal codes still forward the beat, just unrotated.
    always_comb begin
        w_rot     = bus.in_data;
        w_illegal = 1'b0;
        if (bus.in_shift_enable) begin
            if (w_code == 8'd1)
                w_rot = {bus.in_data[0], bus.in_data[DATA_WIDTH-1:1]};
            else if (w_code == 8'd2)
                w_rot = {bus.in_data[1:0], bus.in_data[DATA_WIDTH-1:2]};
            else if (NUM_CLUSTERS == 8 && w_code == 8'd4)
                w_rot = {bus.in_data[3:0], bus.in_data[DATA_WIDTH-1:4]};
            else
                w_illegal = 1'b1;
        end
    end

    assign bus.in_ready  = (r_state != ST_SKID);
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign err_illegal   = r_err;
    assign frame_count   = r_frames;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_xfer   = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_in     = 1'b0;
        w_skid_to_out = 1'b0;
        w_fill_skid   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_in   = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (w_accept && w_xfer) begin
                    w_load_in = 1'b1;
                end else if (w_accept) begin
                    w_fill_skid = 1'b1;
                    w_state_nxt = ST_SKID;
                end else if (w_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_xfer) begin
                    w_skid_to_out = 1'b1;
                    w_state_nxt   = ST_OUT;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
            r_err       <= 1'b0;
            r_frames    <= '0;
        end else begin
            if (w_load_in) begin
                r_out_data <= w_rot;
                r_out_last <= bus.in_last;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_last <= r_skid_last;
            end
            if (w_fill_skid) begin
                r_skid_data <= w_rot;
                r_skid_last <= bus.in_last;
            end
            if (w_accept && w_illegal)
                r_err <= 1'b1;
            if (w_xfer && r_out_last)
                r_frames <= r_frames + 16'd1;
        end
    end
endmodule
